// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole round controller.
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    UP   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 expressed as bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mole_round_scheduler_tick_gen.sv
// Single-cycle game tick enable, one pulse every TICK_DIV cycles while enabled.
module tick_gen #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              cnt <= '0;
    else if (!en)           cnt <= '0;
    else if (cnt == LAST)   cnt <= '0;
    else                    cnt <= cnt + CW'(1);
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/mole_round_scheduler.sv
// Whack-a-mole round controller: mole sequencing, hit judging, score and round timer.
module mole_round_scheduler #(
  parameter int TICK_DIV    = 10_000_000,
  parameter int NUM_MOLES   = 4,
  parameter int UP_TICKS    = 8,
  parameter int GAP_TICKS   = 4,
  parameter int ROUND_TICKS = 600,
  parameter int SCORE_W     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [NUM_MOLES-1:0]               hit,
  output logic [NUM_MOLES-1:0]               mole,
  output logic [SCORE_W-1:0]                 score,
  output logic [$clog2(ROUND_TICKS+1)-1:0]   time_left,
  output logic                               busy,
  output logic                               hit_ok,
  output logic                               miss,
  output logic                               round_done
);
  import mole_pkg::*;

  localparam int HOLE_W = $clog2(NUM_MOLES);
  localparam int TL_W   = $clog2(ROUND_TICKS + 1);
  localparam int PH_MAX = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  state_t               state_q, state_d;
  logic [7:0]           lfsr_q;
  logic [HOLE_W-1:0]    hole_q, hole_d, cand;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [NUM_MOLES-1:0] mole_d;
  logic [SCORE_W-1:0]   score_d;
  logic [TL_W-1:0]      time_d;
  logic                 busy_d, hit_ok_d, miss_d, done_d, tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (busy),
    .tick  (tick)
  );

  // Never repeat the previous hole: bump the candidate by one, wrapping.
  always_comb begin
    cand = lfsr_q[HOLE_W-1:0];
    if (cand == hole_q) cand = cand + HOLE_W'(1);
  end

  // NOTE: every variable gets a default before the case so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    hole_d   = hole_q;
    phase_d  = phase_q;
    mole_d   = mole;
    score_d  = score;
    time_d   = time_left;
    hit_ok_d = 1'b0;
    miss_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = GAP;
          time_d  = TL_W'(ROUND_TICKS);
          score_d = '0;
          phase_d = PH_W'(GAP_TICKS);
          mole_d  = '0;
        end
      end
      GAP: begin
        if (tick) begin
          phase_d = phase_q - PH_W'(1);
          if (phase_q == PH_W'(1)) begin
            hole_d       = cand;
            mole_d       = '0;
            mole_d[cand] = 1'b1;
            phase_d      = PH_W'(UP_TICKS);
            state_d      = UP;
          end
        end
      end
      UP: begin
        if (hit[hole_q]) begin
          if (score != '1) score_d = score + SCORE_W'(1);
          hit_ok_d = 1'b1;
          mole_d   = '0;
          phase_d  = PH_W'(GAP_TICKS);
          state_d  = GAP;
        end else if (|hit) begin
          if (score != '0) score_d = score - SCORE_W'(1);
          miss_d = 1'b1;
        end else if (tick) begin
          phase_d = phase_q - PH_W'(1);
          if (phase_q == PH_W'(1)) begin
            miss_d  = 1'b1;
            mole_d  = '0;
            phase_d = PH_W'(GAP_TICKS);
            state_d = GAP;
          end
        end
      end
      default: ;
    endcase

    // Round expiry overrides the mole phase but keeps any score update above.
    if ((state_q == GAP || state_q == UP) && tick) begin
      time_d = time_left - TL_W'(1);
      if (time_left == TL_W'(1)) begin
        state_d = DONE;
        mole_d  = '0;
        done_d  = 1'b1;
      end
    end

    busy_d = (state_d == GAP) || (state_d == UP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      lfsr_q     <= LFSR_SEED;
      hole_q     <= '0;
      phase_q    <= '0;
      mole       <= '0;
      score      <= '0;
      time_left  <= '0;
      busy       <= 1'b0;
      hit_ok     <= 1'b0;
      miss       <= 1'b0;
      round_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_next(lfsr_q);
      hole_q     <= hole_d;
      phase_q    <= phase_d;
      mole       <= mole_d;
      score      <= score_d;
      time_left  <= time_d;
      busy       <= busy_d;
      hit_ok     <= hit_ok_d;
      miss       <= miss_d;
      round_done <= done_d;
    end
  end

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Directed bench for mole_round_scheduler with hand-timed rounds and an LFSR hole model.
module tb_mole_round_scheduler;

  localparam int TICK_DIV    = 4;
  localparam int NUM_MOLES   = 4;
  localparam int UP_TICKS    = 3;
  localparam int GAP_TICKS   = 2;
  localparam int ROUND_TICKS = 20;
  localparam int SCORE_W     = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [NUM_MOLES-1:0] hit;
  logic [NUM_MOLES-1:0] mole;
  logic [SCORE_W-1:0]   score;
  logic [4:0]           time_left;
  logic                 busy, hit_ok, miss, round_done;

  mole_round_scheduler #(
    .TICK_DIV(TICK_DIV), .NUM_MOLES(NUM_MOLES), .UP_TICKS(UP_TICKS),
    .GAP_TICKS(GAP_TICKS), .ROUND_TICKS(ROUND_TICKS), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .hit(hit), .mole(mole),
    .score(score), .time_left(time_left), .busy(busy), .hit_ok(hit_ok),
    .miss(miss), .round_done(round_done)
  );

  always #5 clk = ~clk;

  // Reference LFSR; m_lfsr_used is the value the DUT saw at the last edge.
  logic [7:0] m_lfsr, m_lfsr_used;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lfsr      <= 8'hA5;
      m_lfsr_used <= 8'hA5;
    end else begin
      m_lfsr_used <= m_lfsr;
      m_lfsr      <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int s     = 0;
  logic [1:0] m_prev;
  logic [1:0] exp_hole;
  logic [NUM_MOLES-1:0] exp_mole;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int e);
    while (cyc - s < e) step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    s = cyc;
  endtask

  task automatic pulse_hit(input logic [NUM_MOLES-1:0] h);
    hit = h;
    step();
    hit = '0;
  endtask

  task automatic check_rise(input string tag);
    logic [1:0] c;
    c = m_lfsr_used[1:0];
    if (c == m_prev) c = c + 2'd1;
    exp_hole = c;
    m_prev   = c;
    exp_mole = 4'b0001 << c;
    check(tag, mole, exp_mole);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_mole"}, mole, 0);
    check({tag, "_score"}, score, 0);
    check({tag, "_time"}, time_left, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pulses"}, {hit_ok, miss, round_done}, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hit = '0; m_prev = 2'd0;
    repeat (3) step();
    check_idle("rst");
    reset = 1'b0;
    step();

    // Round 1
    do_start();
    check("start_busy", busy, 1);
    check("start_time", time_left, 20);
    check("start_score", score, 0);
    run_to(7);
    check("mole_early", mole, 0);
    run_to(8);
    check_rise("mole1");
    check("time_at_mole1", time_left, 18);

    pulse_hit(4'b0001 << (exp_hole + 2'd1));           // e=9 wrong hole, score 0
    check("wrong_miss", miss, 1);
    check("wrong_score_floor", score, 0);
    check("wrong_mole_kept", mole, exp_mole);

    pulse_hit(exp_mole);                                // e=10 correct
    check("hit_ok", hit_ok, 1);
    check("hit_score", score, 1);
    check("hit_mole_clr", mole, 0);

    pulse_hit('1);                                      // e=11 in GAP, ignored
    check("hit_ok_single", hit_ok, 0);
    check("gap_hit_nomiss", miss, 0);
    check("gap_hit_score", score, 1);

    run_to(16);
    check_rise("mole2");
    pulse_hit(4'b0001 << (exp_hole + 2'd1));           // e=17 wrong, 1 -> 0
    check("wrong2_miss", miss, 1);
    check("wrong2_score", score, 0);

    run_to(27);
    check("pre_timeout_mole", mole, exp_mole);
    run_to(28);
    check("timeout_miss", miss, 1);
    check("timeout_mole", mole, 0);
    check("timeout_score", score, 0);

    run_to(36);
    check_rise("mole3");
    run_to(39);
    start = 1'b1;
    step();                                             // e=40 start while busy
    start = 1'b0;
    check("busy_start_time", time_left, 10);
    check("busy_start_mole", mole, exp_mole);

    run_to(56);
    check_rise("mole4");
    run_to(76);
    check_rise("mole5");
    check("time_last", time_left, 1);
    run_to(79);
    pulse_hit(exp_mole);                                // e=80 hit on final tick
    check("final_hit_ok", hit_ok, 1);
    check("final_score", score, 1);
    check("final_done", round_done, 1);
    check("final_busy", busy, 0);
    check("final_mole", mole, 0);
    check("final_time", time_left, 0);
    step();
    check("done_single", round_done, 0);
    step();
    check("done_score_hold", score, 1);

    // Round 2 from DONE, then reset during UP
    do_start();
    check("r2_busy", busy, 1);
    check("r2_time", time_left, 20);
    check("r2_score_clr", score, 0);
    run_to(8);
    check_rise("r2_mole1");
    #2 reset = 1'b1; m_prev = 2'd0;
    #1 check_idle("midrst");
    step();
    step();
    reset = 1'b0;
    step();

    do_start();
    check("r3_time", time_left, 20);
    run_to(7);
    check("r3_mole_early", mole, 0);
    run_to(8);
    check_rise("r3_mole1");
    pulse_hit(exp_mole);
    check("r3_hit_ok", hit_ok, 1);
    check("r3_score", score, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mole_round_scheduler.md
# mole_round_scheduler

Game-round controller for the whack-a-mole design. It sequences one timed round: it raises one mole at a time at a pseudo-random hole and holds it up for a fixed window. It judges button hits against the active mole, keeps the score and the remaining round time, and reports round completion. All timing comes from an internal single-cycle tick enable on `clk`; the block generates no derived clocks. Its outputs feed the mole LEDs and the score/time display drivers.

## Interface
- `TICK_DIV`, 10_000_000: `clk` cycles per game tick (10 Hz at 100 MHz); must be ≥ 2.
- `NUM_MOLES`, 4: number of holes; must be a power of two, 2..16.
- `UP_TICKS`, 8: ticks a mole stays up; must be ≥ 1.
- `GAP_TICKS`, 4: ticks between moles; must be ≥ 1.
- `ROUND_TICKS`, 600: round length in ticks (60 s).
- `SCORE_W`, 8: score width.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: start a round. Level-sampled and acted on only in IDLE or DONE.
- `hit` in NUM_MOLES: debounced, single-cycle button pulses, one bit per hole.
- `mole` out NUM_MOLES: one-hot active mole; all zero when no mole is up.
- `score` out SCORE_W: current score.
- `time_left` out $clog2(ROUND_TICKS+1): remaining ticks in the round.
- `busy` out 1: high in GAP and UP.
- `hit_ok` out 1: one-cycle pulse for a correct hit.
- `miss` out 1: one-cycle pulse for a wrong hole or a mole timeout.
- `round_done` out 1: one-cycle pulse when the round ends.

## Operation
- **Reset values:** state IDLE, `mole`=0, `score`=0, `time_left`=0, `busy`=0, all pulses 0, tick counter 0, LFSR=8'hA5.
- **Tick generation:**
  - The counter runs 0..TICK_DIV-1 only while `busy` is high, and is held at 0 otherwise.
  - `tick` is high for exactly one cycle when the counter equals TICK_DIV-1.
- **Random hole selection:**
  - The 8-bit Fibonacci LFSR (taps 8,6,5,4) advances every cycle, including in IDLE, so the start instant seeds the sequence.
  - The candidate hole is the LFSR's low $clog2(NUM_MOLES) bits.
  - If the candidate equals the previous hole, the block uses candidate+1 mod NUM_MOLES instead.
- **IDLE:** on `start`, go to GAP. Load `time_left`=ROUND_TICKS, clear `score`, and load the phase counter with GAP_TICKS.
- **GAP:**
  - The phase counter decrements on each `tick`.
  - When it reaches 0, latch the hole, drive `mole` one-hot, load the phase counter with UP_TICKS, and go to UP.
- **UP:**
  - **Correct hit** (`hit` bit of the active hole is set, other bits ignored): `score`+1, saturating at 2^SCORE_W-1. Pulse `hit_ok`, clear `mole`, go to GAP.
  - **Wrong hit** (any `hit` bits set, none on the active hole): pulse `miss`, `score`-1 saturating at 0, and stay in UP.
  - **Timeout** (phase counter reaches 0 on a `tick`): pulse `miss` with no score change, clear `mole`, go to GAP.
  - A hit and a timeout `tick` in the same cycle: the hit wins.
- **Round timer:**
  - `time_left` decrements on every `tick` in GAP or UP.
  - When it reaches 0, go to DONE: clear `mole`, pulse `round_done`, drop `busy`.
  - A correct hit in that same cycle is still scored.
- **DONE:** `score` is held. `start` begins a new round exactly as from IDLE.
- `start` while `busy` is high is ignored.
- `hit` in IDLE, GAP or DONE is ignored.

## Timing
- All outputs are registered.
- `start` sampled at edge N gives `busy`=1, `time_left`=ROUND_TICKS and `score`=0 after edge N.
- The first `tick` occurs TICK_DIV cycles after entering GAP.
- `mole` rises in the cycle after the GAP_TICKS-th tick.
- A hit sampled at edge N gives `hit_ok` or `miss`, the score update and the `mole` change after edge N: one cycle of latency.
- Round length is exactly ROUND_TICKS×TICK_DIV cycles from `busy` rising to `round_done`.
- `reset` asserted at any point returns every output to its reset value immediately (asynchronously).

## Structure
- **Package `mole_pkg`:** state enum (IDLE, GAP, UP, DONE), the LFSR seed 8'hA5 and the LFSR tap mask.
- **Sub-module `tick_gen`:** parameterised by TICK_DIV, with an enable input and a single-cycle `tick` output.
- FSM, LFSR, score and timers live in the top module.

## Test plan
Bench parameters: TICK_DIV=4, UP_TICKS=3, GAP_TICKS=2, ROUND_TICKS=20, NUM_MOLES=4.
- **Reset and start:** assert `reset` for 3 cycles, then pulse `start` → all outputs 0 during reset; after `start`, `busy`=1 and `time_left`=20; `mole` rises 8 cycles later.
- **Correct hit:** pulse `hit` on the active hole → `hit_ok` for 1 cycle, `score`=1, `mole`=0 in the next cycle.
- **Wrong hole:** pulse `hit` on a wrong hole with `score`=0 → `miss` pulse, `score` stays 0, `mole` unchanged.
- **Timeout:** no hit for 3 ticks → `miss` pulse, `mole`=0, `score` unchanged.
- **Hit on final tick:** correct hit in the same cycle as the final tick → `score` increments and `round_done` pulses in the same cycle; `busy`=0 and `start` is ignored while busy.
- **Reset mid-round:** assert `reset` during UP → immediate return to reset values; a fresh `start` runs a normal round.
